// File: rtl/fetch_sched_pkg.sv
// fetch_sched_pkg: shared constants and index helpers for the warp fetch scheduler
package fetch_sched_pkg;
    localparam int PC_INC = 4;
    function automatic int wid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int lo(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/rr_multi_grant_arbiter.sv
// rr_multi_grant_arbiter: grants up to K requesters per cycle, scanning N requests from a rotating pointer
//   clk, rst   : clock, synchronous active-high reset
//   req        : N request bits
//   gnt_valid  : K slot-valid bits, packed low, slot 0 nearest the pointer
//   gnt_idx    : K flattened winner indices, slot k at [k*IW +: IW]
module rr_multi_grant_arbiter
    import fetch_sched_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2,
    localparam int IW = wid_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [K-1:0]  gnt_valid,
    output logic [K*IW-1:0] gnt_idx
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_last;
    int            w_cnt;
    always_comb begin
        gnt_valid = '0;
        gnt_idx   = '0;
        w_idx     = '0;
        w_last    = r_ptr;
        w_cnt     = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = r_ptr + IW'(i);
            if (req[w_idx]) begin
                for (int k = 0; k < K; k++) begin
                    if (w_cnt == k) begin
                        gnt_valid[k]              = 1'b1;
                        gnt_idx[lo(k, IW) +: IW]  = w_idx;
                        w_last                    = w_idx;
                    end
                end
                w_cnt = w_cnt + 1;
            end
        end
    end
    // The pointer moves just past the last winner so it gets lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= '0;
        else if (|gnt_valid) r_ptr <= w_last + IW'(1);
    end
endmodule

// File: rtl/warp_fetch_scheduler.sv
// warp_fetch_scheduler: per-warp PC file, rotating multi-grant fetch issue and squashable in-flight tracking
//   clk, rst            : clock, synchronous active-high reset
//   launch_*            : thread manager starts a warp at launch_pc
//   stall, ib_req       : per-warp SIMT stall and I-buffer space
//   redirect_*, exit_*  : per-warp PC redirect (flattened targets) and exit
//   grant_*             : up to NUM_GRANTS fetches issued this cycle
//   ret_*               : surviving fetches arriving at decode
//   active, busy        : per-warp launched state and fetch-outstanding state
module warp_fetch_scheduler
    import fetch_sched_pkg::*;
#(
    parameter int NUM_WARPS  = 8,
    parameter int NUM_GRANTS = 2,
    parameter int PC_W       = 32,
    parameter int FETCH_LAT  = 2,
    localparam int WID_W     = wid_w(NUM_WARPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          launch_valid,
    input  logic [WID_W-1:0]              launch_warp,
    input  logic [PC_W-1:0]               launch_pc,
    input  logic [NUM_WARPS-1:0]          stall,
    input  logic [NUM_WARPS-1:0]          ib_req,
    input  logic [NUM_WARPS-1:0]          redirect_valid,
    input  logic [NUM_WARPS*PC_W-1:0]     redirect_pc,
    input  logic [NUM_WARPS-1:0]          exit_valid,
    output logic [NUM_GRANTS-1:0]         grant_valid,
    output logic [NUM_GRANTS*WID_W-1:0]   grant_warp,
    output logic [NUM_GRANTS*PC_W-1:0]    grant_pc,
    output logic [NUM_GRANTS-1:0]         ret_valid,
    output logic [NUM_GRANTS*WID_W-1:0]   ret_warp,
    output logic [NUM_WARPS-1:0]          active,
    output logic [NUM_WARPS-1:0]          busy
);
    logic [PC_W-1:0]       r_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0]  r_active;
    logic [NUM_GRANTS-1:0] r_fv [FETCH_LAT];
    logic [WID_W-1:0]      r_fw [FETCH_LAT][NUM_GRANTS];
    logic [NUM_WARPS-1:0]  w_kill;
    logic [NUM_WARPS-1:0]  w_busy;
    logic [NUM_WARPS-1:0]  w_gnt;
    logic [NUM_WARPS-1:0]  w_elig;
    always_comb begin
        w_kill    = '0;
        w_busy    = '0;
        w_gnt     = '0;
        grant_pc  = '0;
        ret_valid = '0;
        ret_warp  = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            w_kill[w] = (launch_valid && launch_warp == WID_W'(w)) || exit_valid[w] ||
                        (redirect_valid[w] && r_active[w]);
        for (int s = 0; s < FETCH_LAT; s++)
            for (int g = 0; g < NUM_GRANTS; g++)
                if (r_fv[s][g]) w_busy[r_fw[s][g]] = 1'b1;
        for (int g = 0; g < NUM_GRANTS; g++) begin
            if (grant_valid[g]) begin
                w_gnt[grant_warp[lo(g, WID_W) +: WID_W]] = 1'b1;
                grant_pc[lo(g, PC_W) +: PC_W] = r_pc[grant_warp[lo(g, WID_W) +: WID_W]];
            end
            // A kill arriving in the return cycle still suppresses the fetch.
            ret_valid[g] = r_fv[FETCH_LAT-1][g] && !w_kill[r_fw[FETCH_LAT-1][g]];
            ret_warp[lo(g, WID_W) +: WID_W] = r_fw[FETCH_LAT-1][g];
        end
    end
    assign w_elig = r_active & ~stall & ib_req & ~w_busy & ~w_kill;
    assign active = r_active;
    assign busy   = w_busy;
    rr_multi_grant_arbiter #(.N(NUM_WARPS), .K(NUM_GRANTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (w_elig),
        .gnt_valid (grant_valid),
        .gnt_idx   (grant_warp)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
            for (int w = 0; w < NUM_WARPS; w++) r_pc[w] <= '0;
            for (int s = 0; s < FETCH_LAT; s++) begin
                r_fv[s] <= '0;
                for (int g = 0; g < NUM_GRANTS; g++) r_fw[s][g] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (launch_valid && launch_warp == WID_W'(w)) begin
                    r_pc[w]     <= launch_pc;
                    r_active[w] <= 1'b1;
                end else if (exit_valid[w]) r_active[w] <= 1'b0;
                else if (redirect_valid[w] && r_active[w]) r_pc[w] <= redirect_pc[lo(w, PC_W) +: PC_W];
                else if (w_gnt[w]) r_pc[w] <= r_pc[w] + PC_W'(PC_INC);
            end
            // Granted warps are never killed this cycle, so stage 0 loads unmasked.
            for (int g = 0; g < NUM_GRANTS; g++) begin
                r_fv[0][g] <= grant_valid[g];
                r_fw[0][g] <= grant_warp[lo(g, WID_W) +: WID_W];
            end
            for (int s = 1; s < FETCH_LAT; s++)
                for (int g = 0; g < NUM_GRANTS; g++) begin
                    r_fv[s][g] <= r_fv[s-1][g] && !w_kill[r_fw[s-1][g]];
                    r_fw[s][g] <= r_fw[s-1][g];
                end
        end
    end
endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// tb_warp_fetch_scheduler: directed scenarios plus randomized traffic against a per-warp behavioural model
module tb_warp_fetch_scheduler;
    localparam int NW = 8;
    localparam int NG = 2;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic rst;
    logic launch_valid;
    logic [2:0] launch_warp;
    logic [31:0] launch_pc;
    logic [NW-1:0] stall, ib_req, redirect_valid, exit_valid;
    logic [NW*32-1:0] redirect_pc;
    logic [NG-1:0] grant_valid, ret_valid;
    logic [NG*3-1:0] grant_warp, ret_warp;
    logic [NG*32-1:0] grant_pc;
    logic [NW-1:0] active, busy;
    int n_vec = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    warp_fetch_scheduler dut (
        .clk(clk), .rst(rst), .launch_valid(launch_valid), .launch_warp(launch_warp), .launch_pc(launch_pc),
        .stall(stall), .ib_req(ib_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exit_valid(exit_valid), .grant_valid(grant_valid), .grant_warp(grant_warp), .grant_pc(grant_pc),
        .ret_valid(ret_valid), .ret_warp(ret_warp), .active(active), .busy(busy)
    );
    logic [2:0] d_gw [NG];
    logic [31:0] d_gpc [NG];
    logic [2:0] d_rw [NG];
    always_comb
        for (int g = 0; g < NG; g++) begin
            d_gw[g]  = grant_warp[g*3 +: 3];
            d_gpc[g] = grant_pc[g*32 +: 32];
            d_rw[g]  = ret_warp[g*3 +: 3];
        end
    // Model: one record per warp (at most one outstanding fetch), ages counted in cycles since grant.
    logic [31:0] m_pc [NW];
    logic [NW-1:0] m_act, m_flv;
    int m_age [NW];
    int m_slot [NW];
    int m_ptr;
    logic [NW-1:0] e_kill, e_busy;
    logic [NG-1:0] e_gv, e_rv;
    logic [2:0] e_gw [NG];
    logic [2:0] e_rw [NG];
    logic [31:0] e_gpc [NG];
    function automatic void model_eval();
        int c, w;
        c = 0;
        e_gv = '0;
        e_rv = '0;
        for (int g = 0; g < NG; g++) begin e_gw[g] = '0; e_rw[g] = '0; e_gpc[g] = '0; end
        for (int i = 0; i < NW; i++)
            e_kill[i] = (launch_valid && launch_warp == 3'(i)) || exit_valid[i] || (redirect_valid[i] && m_act[i]);
        e_busy = m_flv;
        for (int i = 0; i < NW; i++) begin
            w = (m_ptr + i) % NW;
            if (m_act[w] && !stall[w] && ib_req[w] && !m_flv[w] && !e_kill[w] && c < NG) begin
                e_gv[c] = 1'b1; e_gw[c] = 3'(w); e_gpc[c] = m_pc[w]; c++;
            end
        end
        for (int i = 0; i < NW; i++)
            if (m_flv[i] && m_age[i] == LAT && !e_kill[i]) begin e_rv[m_slot[i]] = 1'b1; e_rw[m_slot[i]] = 3'(i); end
    endfunction
    function automatic void model_step();
        int last;
        logic [NW-1:0] gnt;
        model_eval();
        if (rst) begin
            m_act = '0; m_flv = '0; m_ptr = 0;
            for (int i = 0; i < NW; i++) begin m_pc[i] = '0; m_age[i] = 0; m_slot[i] = 0; end
            return;
        end
        for (int i = 0; i < NW; i++)
            if (m_flv[i]) begin
                if (e_kill[i] || m_age[i] == LAT) m_flv[i] = 1'b0;
                else m_age[i]++;
            end
        gnt = '0;
        last = -1;
        for (int g = 0; g < NG; g++)
            if (e_gv[g]) begin
                m_flv[e_gw[g]] = 1'b1; m_age[e_gw[g]] = 1; m_slot[e_gw[g]] = g; gnt[e_gw[g]] = 1'b1; last = int'(e_gw[g]);
            end
        if (last >= 0) m_ptr = (last + 1) % NW;
        for (int i = 0; i < NW; i++) begin
            if (launch_valid && launch_warp == 3'(i)) begin m_pc[i] = launch_pc; m_act[i] = 1'b1; end
            else if (exit_valid[i]) m_act[i] = 1'b0;
            else if (redirect_valid[i] && m_act[i]) m_pc[i] = redirect_pc[i*32 +: 32];
            else if (gnt[i]) m_pc[i] = m_pc[i] + 32'd4;
        end
    endfunction
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        launch_valid = 1'b0; launch_warp = '0; launch_pc = '0; stall = '0; ib_req = '1;
        redirect_valid = '0; redirect_pc = '0; exit_valid = '0;
    endtask
    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask
    task automatic launch(input logic [2:0] w, input logic [31:0] pc);
        launch_valid = 1'b1; launch_warp = w; launch_pc = pc; tick(); launch_valid = 1'b0;
    endtask
    task automatic test_reset();
        idle(); rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
        n_vec++; if (grant_valid !== 2'b00) begin n_err++; $display("FAIL reset_gv got %b want 00", grant_valid); end
        n_vec++; if (ret_valid !== 2'b00) begin n_err++; $display("FAIL reset_rv got %b want 00", ret_valid); end
        n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL reset_busy got %h want 00", busy); end
        n_vec++; if (active !== 8'h00) begin n_err++; $display("FAIL reset_active got %h want 00", active); end
        n_vec++; if (grant_warp !== 6'h0 || grant_pc !== 64'h0 || ret_warp !== 6'h0) begin
            n_err++; $display("FAIL reset_fields got gw=%h gpc=%h rw=%h want 0", grant_warp, grant_pc, ret_warp); end
    endtask
    task automatic test_single_warp();
        idle(); do_reset(); launch(3'd3, 32'h100); #1;
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd3 || d_gpc[0] !== 32'h100) begin
            n_err++; $display("FAIL single_grant got v=%b w=%0d pc=%h want 01/3/100", grant_valid, d_gw[0], d_gpc[0]); end
        tick();
        n_vec++; if (busy !== 8'h08 || grant_valid !== 2'b00) begin
            n_err++; $display("FAIL single_busy1 got busy=%h v=%b want 08/00", busy, grant_valid); end
        tick();
        n_vec++; if (busy !== 8'h08 || ret_valid !== 2'b01 || d_rw[0] !== 3'd3) begin
            n_err++; $display("FAIL single_ret got busy=%h rv=%b rw=%0d want 08/01/3", busy, ret_valid, d_rw[0]); end
        tick();
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd3 || d_gpc[0] !== 32'h104 || busy !== 8'h00) begin
            n_err++; $display("FAIL single_regrant got v=%b w=%0d pc=%h busy=%h want 01/3/104/00", grant_valid, d_gw[0], d_gpc[0], busy); end
        tick();
    endtask
    task automatic test_round_robin();
        int cnt [3];
        idle(); do_reset(); ib_req = '0;
        launch(3'd0, 32'h0); launch(3'd1, 32'h40); launch(3'd2, 32'h80);
        ib_req = '1; #1;
        n_vec++; if (grant_valid !== 2'b11 || d_gw[0] !== 3'd0 || d_gw[1] !== 3'd1 || d_gpc[0] !== 32'h0 || d_gpc[1] !== 32'h40) begin
            n_err++; $display("FAIL rr_pair got v=%b w=%0d,%0d pc=%h,%h want 11/0,1/0,40", grant_valid, d_gw[0], d_gw[1], d_gpc[0], d_gpc[1]); end
        tick();
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd2 || d_gpc[0] !== 32'h80) begin
            n_err++; $display("FAIL rr_next got v=%b w=%0d pc=%h want 01/2/80", grant_valid, d_gw[0], d_gpc[0]); end
        tick();
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int c = 0; c < 20; c++) begin
            for (int g = 0; g < NG; g++) if (grant_valid[g] && d_gw[g] < 3'd3) cnt[d_gw[g]]++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (cnt[i] < 5) begin n_err++; $display("FAIL rr_starve warp %0d got %0d grants want >=5", i, cnt[i]); end
        end
    endtask
    task automatic test_redirect();
        idle(); do_reset(); ib_req = '0; launch(3'd1, 32'h40); ib_req = '1; #1;
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd1) begin
            n_err++; $display("FAIL redir_grant got v=%b w=%0d want 01/1", grant_valid, d_gw[0]); end
        tick();
        redirect_valid[1] = 1'b1; redirect_pc[32 +: 32] = 32'h200; #1;
        n_vec++; if (busy !== 8'h02 || ret_valid !== 2'b00) begin
            n_err++; $display("FAIL redir_busy got busy=%h rv=%b want 02/00", busy, ret_valid); end
        tick(); redirect_valid = '0; #1;
        n_vec++; if (busy !== 8'h00 || ret_valid !== 2'b00) begin
            n_err++; $display("FAIL redir_squash got busy=%h rv=%b want 00/00", busy, ret_valid); end
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd1 || d_gpc[0] !== 32'h200) begin
            n_err++; $display("FAIL redir_pc got v=%b w=%0d pc=%h want 01/1/200", grant_valid, d_gw[0], d_gpc[0]); end
        tick();
    endtask
    task automatic test_exit_launch();
        idle(); do_reset(); ib_req = '0; launch(3'd0, 32'h0);
        ib_req = '1; exit_valid = 8'h21; launch_valid = 1'b1; launch_warp = 3'd5; launch_pc = 32'h500; #1;
        n_vec++; if (grant_valid !== 2'b00) begin n_err++; $display("FAIL exit_nogrant got %b want 00", grant_valid); end
        tick(); idle(); #1;
        n_vec++; if (active !== 8'h20) begin n_err++; $display("FAIL exit_active got %h want 20", active); end
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd5 || d_gpc[0] !== 32'h500) begin
            n_err++; $display("FAIL launch_wins got v=%b w=%0d pc=%h want 01/5/500", grant_valid, d_gw[0], d_gpc[0]); end
        tick();
    endtask
    task automatic test_wrap_stall();
        idle(); do_reset(); ib_req = '0;
        launch(3'd2, 32'hFFFFFFFC); launch(3'd4, 32'h10); launch(3'd6, 32'h20);
        ib_req = 8'hBF; stall = 8'h10; #1;
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd2 || d_gpc[0] !== 32'hFFFFFFFC) begin
            n_err++; $display("FAIL wrap_first got v=%b w=%0d pc=%h want 01/2/fffffffc", grant_valid, d_gw[0], d_gpc[0]); end
        tick();
        for (int c = 0; c < 2; c++) begin
            n_vec++; if (grant_valid !== 2'b00) begin n_err++; $display("FAIL gate_block got %b want 00", grant_valid); end
            tick();
        end
        n_vec++; if (grant_valid !== 2'b01 || d_gw[0] !== 3'd2 || d_gpc[0] !== 32'h0) begin
            n_err++; $display("FAIL wrap_pc got v=%b w=%0d pc=%h want 01/2/0", grant_valid, d_gw[0], d_gpc[0]); end
        tick(); stall = '0; ib_req = '1; #1;
        n_vec++; if (grant_valid !== 2'b11 || d_gw[0] !== 3'd4 || d_gw[1] !== 3'd6 || d_gpc[0] !== 32'h10 || d_gpc[1] !== 32'h20) begin
            n_err++; $display("FAIL gate_release got v=%b w=%0d,%0d pc=%h,%h want 11/4,6/10,20", grant_valid, d_gw[0], d_gw[1], d_gpc[0], d_gpc[1]); end
        tick();
    endtask
    task automatic test_reset_midflight();
        idle(); do_reset(); ib_req = '0; launch(3'd0, 32'h0); launch(3'd1, 32'h40); ib_req = '1; #1;
        n_vec++; if (grant_valid !== 2'b11) begin n_err++; $display("FAIL mid_grant got %b want 11", grant_valid); end
        tick(); rst = 1'b1; tick(); rst = 1'b0; #1;
        n_vec++; if (ret_valid !== 2'b00 || busy !== 8'h00 || active !== 8'h00) begin
            n_err++; $display("FAIL mid_reset got rv=%b busy=%h act=%h want 00/00/00", ret_valid, busy, active); end
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (grant_valid !== 2'b00 || ret_valid !== 2'b00) begin
                n_err++; $display("FAIL mid_quiet got v=%b rv=%b want 00/00", grant_valid, ret_valid); end
            tick();
        end
    endtask
    task automatic test_random();
        idle(); do_reset();
        for (int n = 0; n < 800; n++) begin
            launch_valid = ($urandom_range(5) == 0);
            launch_warp = 3'($urandom_range(7));
            launch_pc = ($urandom_range(3) == 0) ? 32'hFFFFFFF4 : ($urandom & 32'hFFFFFFFC);
            for (int w = 0; w < NW; w++) begin
                stall[w] = ($urandom_range(3) == 0);
                ib_req[w] = ($urandom_range(3) != 0);
                redirect_valid[w] = ($urandom_range(15) == 0);
                redirect_pc[w*32 +: 32] = $urandom & 32'hFFFFFFFC;
                exit_valid[w] = ($urandom_range(39) == 0);
            end
            rst = ($urandom_range(249) == 0);
            #1;
            model_eval();
            n_vec++; if (grant_valid !== e_gv) begin n_err++; if (n_err < 30) $display("FAIL rnd_gv cyc %0d got %b want %b", n, grant_valid, e_gv); end
            n_vec++; if (ret_valid !== e_rv) begin n_err++; if (n_err < 30) $display("FAIL rnd_rv cyc %0d got %b want %b", n, ret_valid, e_rv); end
            n_vec++; if (active !== m_act || busy !== e_busy) begin
                n_err++; if (n_err < 30) $display("FAIL rnd_state cyc %0d got act=%h busy=%h want %h/%h", n, active, busy, m_act, e_busy); end
            for (int g = 0; g < NG; g++) begin
                if (e_gv[g]) begin
                    n_vec++; if (d_gw[g] !== e_gw[g] || d_gpc[g] !== e_gpc[g]) begin
                        n_err++; if (n_err < 30) $display("FAIL rnd_grant cyc %0d slot %0d got w=%0d pc=%h want %0d/%h", n, g, d_gw[g], d_gpc[g], e_gw[g], e_gpc[g]); end
                end
                if (e_rv[g]) begin
                    n_vec++; if (d_rw[g] !== e_rw[g]) begin
                        n_err++; if (n_err < 30) $display("FAIL rnd_ret cyc %0d slot %0d got w=%0d want %0d", n, g, d_rw[g], e_rw[g]); end
                end
            end
            tick();
        end
        rst = 1'b0; idle();
    endtask
    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_warp();
        test_round_robin();
        test_redirect();
        test_exit_launch();
        test_wrap_stall();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
